// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: RS232 transmitter with a small byte FIFO in front of it.
// Each frame is start bit, 5..8 data bits sent LSB first, optional parity,
// and 1 or 2 stop bits. Every bit lasts div clk cycles.
// The line settings are captured when a byte leaves the FIFO. Changing them
// during a frame therefore only affects the next frame.
module rs232_tx_fifo #(
  parameter int DIV_W   = 12,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   div,
  input  logic [1:0]         nbits,
  input  logic               par_en,
  input  logic               par_odd,
  input  logic               stop2,
  input  logic               wr,
  input  logic [7:0]         wdata,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               ovf,
  output logic               TxD
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [7:0]         rd_data;
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count, count_next;

  state_t             state;
  logic [DIV_W-1:0]   tick, div_l;
  logic [2:0]         bitcnt;
  logic [1:0]         nbits_l;
  logic               par_en_l, par_odd_l, stop2_l, par_bit, stopcnt;
  logic [7:0]         shreg;
  logic [7:0]         data_mask;

  logic wr_acc, tick_end, last_stop, pop;

  // full reflects the registered count, so a pop on the same edge cannot make room for this write
  assign wr_acc    = wr & ~full;
  assign tick_end  = (tick == div_l - DIV_W'(1));
  assign last_stop = (state == STOP) && tick_end && (stopcnt == stop2_l);
  // count is the pre-edge value, so a byte written into an empty FIFO waits one edge before it is popped
  assign pop       = ((state == IDLE) || last_stop) && (count != '0);
  assign data_mask = 8'hff >> (2'd3 - nbits_l);
  assign level     = count;
  assign busy      = (state != IDLE) || (count != '0);

  // Next occupancy from this edge's accepted write and pop
  always_comb begin
    count_next = count;
    if (wr_acc && !pop)
      count_next = count + 1'b1;
    else if (!wr_acc && pop)
      count_next = count - 1'b1;
  end

  // FIFO storage with registered read; the head byte is read on pop and is consumed at the end of the start bit
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr] <= wdata;
    if (pop)
      rd_data <= mem[rptr];
  end

  // FIFO pointers, occupancy, full flag and overflow pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (FIFO_AW+1)'(DEPTH));
      ovf   <= wr & full;
    end
  end

  // Frame sequencer with registered TxD; a pop on the final stop tick chains directly into the next start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      TxD       <= 1'b1;
      tick      <= '0;
      div_l     <= DIV_W'(2);
      bitcnt    <= '0;
      nbits_l   <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      par_bit   <= 1'b0;
      stopcnt   <= 1'b0;
      shreg     <= '0;
    end else if (pop) begin
      state     <= START;
      TxD       <= 1'b0;
      tick      <= '0;
      div_l     <= (div < DIV_W'(2)) ? DIV_W'(2) : div;
      nbits_l   <= nbits;
      par_en_l  <= par_en;
      par_odd_l <= par_odd;
      stop2_l   <= stop2;
    end else begin
      case (state)
        IDLE: begin
          TxD <= 1'b1;
        end
        START: begin
          if (tick_end) begin
            tick    <= '0;
            state   <= DATA;
            bitcnt  <= '0;
            TxD     <= rd_data[0];
            shreg   <= rd_data >> 1;
            par_bit <= (^(rd_data & data_mask)) ^ par_odd_l;
          end else begin
            tick <= tick + DIV_W'(1);
          end
        end
        DATA: begin
          if (tick_end) begin
            tick <= '0;
            if (bitcnt == 3'(nbits_l) + 3'd4) begin
              if (par_en_l) begin
                state <= PARITY;
                TxD   <= par_bit;
              end else begin
                state   <= STOP;
                TxD     <= 1'b1;
                stopcnt <= 1'b0;
              end
            end else begin
              bitcnt <= bitcnt + 3'd1;
              TxD    <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end else begin
            tick <= tick + DIV_W'(1);
          end
        end
        PARITY: begin
          if (tick_end) begin
            tick    <= '0;
            state   <= STOP;
            TxD     <= 1'b1;
            stopcnt <= 1'b0;
          end else begin
            tick <= tick + DIV_W'(1);
          end
        end
        STOP: begin
          if (tick_end) begin
            tick <= '0;
            if (last_stop) begin
              state <= IDLE;
            end else begin
              stopcnt <= 1'b1;
            end
          end else begin
            tick <= tick + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// tb_rs232_tx_fifo: checks rs232_tx_fifo cycle by cycle against a waveform model.
// On each pop, the model expands a frame into per-cycle TxD values.
module tb_rs232_tx_fifo;

  localparam int DIV_W   = 12;
  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] div = 12'd4;
  logic [1:0]       nbits = 2'd3;
  logic             par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0, wr = 1'b0;
  logic [7:0]       wdata = 8'h00;
  logic             full, busy, ovf, TxD;
  logic [FIFO_AW:0] level;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] m_q[$];
  bit         m_wave[$];
  bit         m_txd = 1'b1, m_inframe = 1'b0, m_ovf = 1'b0;

  rs232_tx_fifo #(.DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .div(div), .nbits(nbits), .par_en(par_en),
    .par_odd(par_odd), .stop2(stop2), .wr(wr), .wdata(wdata),
    .full(full), .level(level), .busy(busy), .ovf(ovf), .TxD(TxD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Append one full frame, one entry per clk cycle, using the current line settings
  task automatic build_frame(input logic [7:0] b);
    int d, n;
    bit p;
    d = (div < 2) ? 2 : int'(div);
    n = int'(nbits) + 5;
    p = 1'b0;
    for (int k = 0; k < d; k++) m_wave.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      p ^= b[i];
      for (int k = 0; k < d; k++) m_wave.push_back(b[i]);
    end
    if (par_en)
      for (int k = 0; k < d; k++) m_wave.push_back(p ^ par_odd);
    for (int k = 0; k < d; k++) m_wave.push_back(1'b1);
    if (stop2)
      for (int k = 0; k < d; k++) m_wave.push_back(1'b1);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wave.delete();
    m_txd = 1'b1;
    m_inframe = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock edge: the pop decision and the full test both use the occupancy before the edge
  task automatic model_step();
    int pre;
    pre = m_q.size();
    if (m_wave.size() == 0 && pre > 0) build_frame(m_q.pop_front());
    if (m_wave.size() > 0) begin
      m_txd = m_wave.pop_front();
      m_inframe = 1'b1;
    end else begin
      m_txd = 1'b1;
      m_inframe = 1'b0;
    end
    m_ovf = wr && (pre == DEPTH);
    if (wr && pre < DEPTH) m_q.push_back(wdata);
  endtask

  task automatic tick_cmp();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check("txd",   {31'b0, TxD},  {31'b0, m_txd});
    check("level", {28'b0, level}, m_q.size());
    check("full",  {31'b0, full}, {31'b0, (m_q.size() == DEPTH)});
    check("busy",  {31'b0, busy}, {31'b0, (m_inframe || m_q.size() != 0)});
    check("ovf",   {31'b0, ovf},  {31'b0, m_ovf});
  endtask

  task automatic write_byte(input logic [7:0] b);
    wdata = b;
    wr = 1'b1;
    tick_cmp();
    wr = 1'b0;
    $display("wr %02h div=%0d nbits=%0d par_en=%0d odd=%0d stop2=%0d level=%0d ovf=%0d",
             b, div, nbits, par_en, par_odd, stop2, level, ovf);
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while ((busy || m_inframe || m_q.size() != 0) && c < bound) begin
      tick_cmp();
      c++;
    end
    if (c >= bound) check("idle_timeout", {31'b0, busy}, 32'd0);
    repeat (3) tick_cmp();
  endtask

  task automatic set_cfg(input int d, input int nb, input bit pe, input bit po, input bit s2);
    div = DIV_W'(d);
    nbits = 2'(nb);
    par_en = pe;
    par_odd = po;
    stop2 = s2;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_txd",   {31'b0, TxD},  32'd1);
    check("rst_level", {28'b0, level}, 32'd0);
    check("rst_full",  {31'b0, full}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_ovf",   {31'b0, ovf},  32'd0);
    model_reset();
    repeat (3) tick_cmp();
    rst = 1'b1;
    repeat (2) tick_cmp();

    // 8N1 at div 217, byte 0x55
    set_cfg(217, 3, 0, 0, 0);
    write_byte(8'h55);
    tick_cmp();
    check("t1_start_bit", {31'b0, TxD}, 32'd0);
    wait_idle(5000);

    // 7 data bits, even parity, two stop bits, byte 0x83
    set_cfg(4, 2, 1, 0, 1);
    write_byte(8'h83);
    wait_idle(200);

    // 5 data bits, odd parity, byte 0xFF
    set_cfg(3, 0, 1, 1, 0);
    write_byte(8'hFF);
    wait_idle(200);

    // Back-to-back writes until overflow
    set_cfg(3, 3, 0, 0, 0);
    for (int i = 0; i < 9; i++) write_byte(8'(8'h10 + i));
    check("t4_level9", {28'b0, level}, 32'd8);
    check("t4_full9",  {31'b0, full},  32'd1);
    write_byte(8'hEE);
    check("t4_ovf",    {31'b0, ovf},   32'd1);
    check("t4_level10", {28'b0, level}, 32'd8);
    tick_cmp();
    check("t4_ovf_clr", {31'b0, ovf},  32'd0);
    wait_idle(2000);

    // Settings changed mid-frame apply to the next frame only
    set_cfg(5, 3, 0, 0, 0);
    write_byte(8'hA5);
    write_byte(8'h3C);
    repeat (12) tick_cmp();
    set_cfg(3, 1, 1, 0, 1);
    wait_idle(500);

    // Reset in the middle of the data bits
    set_cfg(6, 3, 0, 0, 0);
    write_byte(8'h96);
    repeat (29) tick_cmp();
    rst = 1'b0;
    #1;
    check("t6_txd",   {31'b0, TxD},  32'd1);
    check("t6_level", {28'b0, level}, 32'd0);
    check("t6_busy",  {31'b0, busy}, 32'd0);
    model_reset();
    repeat (2) tick_cmp();
    rst = 1'b1;
    tick_cmp();
    write_byte(8'h4B);
    wait_idle(500);

    // Randomized bursts with random line settings, including divisors below 2
    for (int b = 0; b < 25; b++) begin
      set_cfg($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      $display("burst %0d div=%0d nbits=%0d par_en=%0d odd=%0d stop2=%0d",
               b, div, nbits, par_en, par_odd, stop2);
      for (int c = 0; c < 40; c++) begin
        wr = 1'($urandom_range(0, 1));
        wdata = 8'($urandom);
        if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 6));
        if ($urandom_range(0, 19) == 0) nbits = 2'($urandom_range(0, 3));
        tick_cmp();
      end
      wr = 1'b0;
      wait_idle(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
